// File: rtl/demod_pkg.sv
// Shared definitions for the windowed I/Q integrator:
// register map, channel FSM states and output scaling.
package demod_pkg;

  localparam logic [1:0] REG_DELAY  = 2'd0;
  localparam logic [1:0] REG_LENGTH = 2'd1;
  localparam logic [1:0] REG_SHIFT  = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    INTEG,
    FLUSH
  } chanState_t;

  // Floor shift, then clamp to a signed outW-bit range.
  function automatic logic signed [63:0] sat_shift(
    input logic signed [63:0] acc,
    input logic        [4:0]  sh,
    input int                 outW
  );
    logic signed [63:0] shifted;
    logic signed [63:0] maxV;
    logic signed [63:0] minV;
    shifted = acc >>> sh;
    maxV    = (64'sd1 <<< (outW - 1)) - 64'sd1;
    minV    = -maxV - 64'sd1;
    if (shifted > maxV)
      sat_shift = maxV;
    else if (shifted < minV)
      sat_shift = minV;
    else
      sat_shift = shifted;
  endfunction

endpackage

// File: rtl/iq_window_chan.sv
// One I/Q channel: trigger FSM, beat counters,
// lane adder, accumulators and scaled output stage.
module iq_window_chan
  import demod_pkg::*;
#(
  parameter int LANES = 5,
  parameter int IN_W  = 16,
  parameter int ACC_W = 40,
  parameter int OUT_W = 32,
  parameter int LEN_W = 16
) (
  input  logic                  clk100,
  input  logic                  reset,
  input  logic                  cfgWe,
  input  logic [1:0]            cfgReg,
  input  logic [LEN_W-1:0]      cfgData,
  input  logic                  trigger,
  input  logic                  inValid,
  input  logic [LANES*IN_W-1:0] iIn,
  input  logic [LANES*IN_W-1:0] qIn,
  output logic                  iqValid,
  output logic [OUT_W-1:0]      iVal,
  output logic [OUT_W-1:0]      qVal,
  output logic                  busy,
  output logic                  overrun
);

  chanState_t state, stateNext;

  logic [LEN_W-1:0] cfgDelay;
  logic [LEN_W-1:0] cfgLength;
  logic [4:0]       cfgShift;
  logic [LEN_W-1:0] wDelay;
  logic [LEN_W-1:0] wLength;
  logic [4:0]       wShift;
  logic [LEN_W-1:0] dlyCnt;
  logic [LEN_W-1:0] lenCnt;

  logic flushCnt;
  logic takeD;
  logic start;
  logic take;
  logic skip;
  logic lastBeat;
  logic done;

  logic signed [ACC_W-1:0] laneI, laneQ;
  logic signed [ACC_W-1:0] sumI, sumQ;
  logic signed [ACC_W-1:0] accI, accQ;

  assign busy = (state != IDLE);

  always_comb begin
    laneI = '0;
    laneQ = '0;
    for (int l = 0; l < LANES; l++) begin
      laneI += ACC_W'($signed(iIn[l*IN_W +: IN_W]));
      laneQ += ACC_W'($signed(qIn[l*IN_W +: IN_W]));
    end
  end

  // Once the delay count is met, the very next beat
  // is already part of the window, even in DELAY.
  always_comb begin
    stateNext = state;
    start     = (state == IDLE) && trigger;
    take      = inValid &&
                ((state == INTEG) ||
                 ((state == DELAY) && (dlyCnt == wDelay)));
    skip      = inValid && (state == DELAY) &&
                (dlyCnt != wDelay);
    lastBeat  = take && (lenCnt == wLength - LEN_W'(1));
    done      = (state == FLUSH) && flushCnt;
    unique case (state)
      IDLE:  if (start) stateNext = DELAY;
      DELAY,
      INTEG: begin
        if (lastBeat)  stateNext = FLUSH;
        else if (take) stateNext = INTEG;
      end
      FLUSH: if (flushCnt) stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      cfgDelay  <= '0;
      cfgLength <= LEN_W'(1);
      cfgShift  <= '0;
      wDelay    <= '0;
      wLength   <= LEN_W'(1);
      wShift    <= '0;
      dlyCnt    <= '0;
      lenCnt    <= '0;
      flushCnt  <= 1'b0;
      takeD     <= 1'b0;
      sumI      <= '0;
      sumQ      <= '0;
      accI      <= '0;
      accQ      <= '0;
      iqValid   <= 1'b0;
      iVal      <= '0;
      qVal      <= '0;
      overrun   <= 1'b0;
    end else begin
      if (cfgWe) begin
        case (cfgReg)
          REG_DELAY:  cfgDelay  <= cfgData;
          REG_LENGTH: cfgLength <= cfgData;
          REG_SHIFT:  cfgShift  <= cfgData[4:0];
          default:    ;
        endcase
      end
      if (skip) dlyCnt <= dlyCnt + LEN_W'(1);
      if (take) lenCnt <= lenCnt + LEN_W'(1);
      flushCnt <= (state == FLUSH) && !flushCnt;
      sumI     <= laneI;
      sumQ     <= laneQ;
      takeD    <= take;
      if (takeD) begin
        accI <= accI + sumI;
        accQ <= accQ + sumQ;
      end
      if (start) begin
        wDelay  <= cfgDelay;
        wLength <= (cfgLength == '0) ? LEN_W'(1)
                                     : cfgLength;
        wShift  <= cfgShift;
        dlyCnt  <= '0;
        lenCnt  <= '0;
        accI    <= '0;
        accQ    <= '0;
      end
      iqValid <= done;
      if (done) begin
        iVal <= OUT_W'(sat_shift(64'(accI), wShift, OUT_W));
        qVal <= OUT_W'(sat_shift(64'(accQ), wShift, OUT_W));
      end
      if (trigger && busy) overrun <= 1'b1;
    end
  end

endmodule

// File: rtl/iq_window_integrator.sv
// Multi-channel windowed I/Q integrator: config write
// decode plus one iq_window_chan per channel.
module iq_window_integrator
  import demod_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int LANES  = 5,
  parameter int IN_W   = 16,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 32,
  parameter int LEN_W  = 16
) (
  input  logic                         clk100,
  input  logic                         reset,
  input  logic                         cfg_wr_en,
  input  logic [7:0]                   cfg_addr,
  input  logic [31:0]                  cfg_wr_data,
  input  logic [NUM_CH-1:0]            trigger,
  input  logic                         in_valid,
  input  logic [NUM_CH*LANES*IN_W-1:0] i_in,
  input  logic [NUM_CH*LANES*IN_W-1:0] q_in,
  output logic [NUM_CH-1:0]            iq_valid,
  output logic [NUM_CH*OUT_W-1:0]      i_val,
  output logic [NUM_CH*OUT_W-1:0]      q_val,
  output logic [NUM_CH-1:0]            busy,
  output logic [NUM_CH-1:0]            overrun
);

  localparam int BEAT_W = LANES * IN_W;

  logic [5:0] chSel;
  logic [1:0] regSel;
  logic       regOk;
  logic       unusedCfgHi;

  assign chSel       = cfg_addr[7:2];
  assign regSel      = cfg_addr[1:0];
  assign regOk       = (regSel != 2'd3);
  assign unusedCfgHi = ^cfg_wr_data[31:LEN_W];

  for (genvar c = 0; c < NUM_CH; c++) begin : gCh
    logic chWe;
    assign chWe = cfg_wr_en && regOk &&
                  (chSel == 6'(c));

    iq_window_chan #(
      .LANES (LANES),
      .IN_W  (IN_W),
      .ACC_W (ACC_W),
      .OUT_W (OUT_W),
      .LEN_W (LEN_W)
    ) uChan (
      .clk100  (clk100),
      .reset   (reset),
      .cfgWe   (chWe),
      .cfgReg  (regSel),
      .cfgData (cfg_wr_data[LEN_W-1:0]),
      .trigger (trigger[c]),
      .inValid (in_valid),
      .iIn     (i_in[c*BEAT_W +: BEAT_W]),
      .qIn     (q_in[c*BEAT_W +: BEAT_W]),
      .iqValid (iq_valid[c]),
      .iVal    (i_val[c*OUT_W +: OUT_W]),
      .qVal    (q_val[c*OUT_W +: OUT_W]),
      .busy    (busy[c]),
      .overrun (overrun[c])
    );
  end

endmodule
